// File: rtl/alarm_controller_if.sv
// Bus between the alarm controller and its surroundings: current time digits,
// user controls, stored-alarm digits for the display and the alarm status outputs.
interface alarm_controller_if;
  logic       tick_1hz;
  logic       alarm_en;
  logic       set_alarm;
  logic [5:0] alarm_mins;
  logic [4:0] alarm_hrs;
  logic       snooze_btn;
  logic       stop_btn;
  logic [3:0] sec_units;
  logic [3:0] min_units;
  logic [3:0] hour_units;
  logic [2:0] sec_tens;
  logic [2:0] min_tens;
  logic [2:0] hour_tens;
  logic [3:0] al_min_units;
  logic [3:0] al_hour_units;
  logic [2:0] al_min_tens;
  logic [2:0] al_hour_tens;
  logic       alarm_ringing;
  logic       buzzer;
  logic       snooze_active;

  // Drives time/controls, observes alarm digits and status.
  modport master (
    output tick_1hz, alarm_en, set_alarm, alarm_mins, alarm_hrs, snooze_btn, stop_btn,
    output sec_units, min_units, hour_units, sec_tens, min_tens, hour_tens,
    input  al_min_units, al_hour_units, al_min_tens, al_hour_tens,
    input  alarm_ringing, buzzer, snooze_active
  );

  // The alarm controller itself.
  modport slave (
    input  tick_1hz, alarm_en, set_alarm, alarm_mins, alarm_hrs, snooze_btn, stop_btn,
    input  sec_units, min_units, hour_units, sec_tens, min_tens, hour_tens,
    output al_min_units, al_hour_units, al_min_tens, al_hour_tens,
    output alarm_ringing, buzzer, snooze_active
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm controller: stores an alarm time as BCD, detects the HH:MM:00 match against
// the running clock and sequences ringing, snoozing and stopping of the buzzer.
module alarm_controller #(
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input logic               clk,
  input logic               reset,
  alarm_controller_if.slave bus
);

  localparam int unsigned SnoozeTicks = SNOOZE_MIN * 60;
  localparam int unsigned RingW       = $clog2(RING_TIMEOUT_S + 1);
  localparam int unsigned TmrW        = $clog2(SnoozeTicks + 1);
  localparam int unsigned SnzW        = $clog2(MAX_SNOOZE + 1);

  typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnooze} state_e;

  state_e           state_q, state_d;
  logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [SnzW-1:0]  snooze_cnt_q, snooze_cnt_d;
  logic             buzzer_q, buzzer_d;
  logic             match_d_q, match_d_d;
  logic [3:0]       al_min_units_q, al_min_units_d;
  logic [2:0]       al_min_tens_q, al_min_tens_d;
  logic [3:0]       al_hour_units_q, al_hour_units_d;
  logic [2:0]       al_hour_tens_q, al_hour_tens_d;

  logic set_valid;
  logic match;
  logic trig;

  // Alarm time capture with range check and binary-to-BCD conversion.
  always_comb begin
    set_valid       = bus.set_alarm && (bus.alarm_mins <= 6'd59) && (bus.alarm_hrs <= 5'd23);
    al_min_units_d  = al_min_units_q;
    al_min_tens_d   = al_min_tens_q;
    al_hour_units_d = al_hour_units_q;
    al_hour_tens_d  = al_hour_tens_q;
    if (set_valid) begin
      al_min_units_d  = 4'(bus.alarm_mins % 6'd10);
      al_min_tens_d   = 3'(bus.alarm_mins / 6'd10);
      al_hour_units_d = 4'(bus.alarm_hrs % 5'd10);
      al_hour_tens_d  = 3'(bus.alarm_hrs / 5'd10);
    end
  end

  // Time-of-day match and its rising edge, so a held 00 second triggers only once.
  always_comb begin
    match = (bus.hour_tens == al_hour_tens_q) && (bus.hour_units == al_hour_units_q) &&
            (bus.min_tens == al_min_tens_q) && (bus.min_units == al_min_units_q) &&
            (bus.sec_tens == 3'd0) && (bus.sec_units == 4'd0);
    trig      = match && !match_d_q;
    match_d_d = match;
  end

  // Next-state logic; later overrides implement set_alarm and alarm_en priority.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    tmr_d        = tmr_q;
    snooze_cnt_d = snooze_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.alarm_en) state_d = StArmed;
      end
      StArmed: begin
        if (trig) begin
          state_d      = StRinging;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end
      end
      StRinging: begin
        if (bus.stop_btn) begin
          state_d = StArmed;
        end else if (bus.snooze_btn) begin
          if (snooze_cnt_q < SnzW'(MAX_SNOOZE)) begin
            state_d      = StSnooze;
            snooze_cnt_d = snooze_cnt_q + 1'b1;
            tmr_d        = '0;
          end else begin
            state_d = StArmed;
          end
        end else if (bus.tick_1hz) begin
          if (ring_cnt_q == RingW'(RING_TIMEOUT_S - 1)) state_d = StArmed;
          else ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      StSnooze: begin
        if (bus.stop_btn) begin
          state_d = StArmed;
        end else if (bus.tick_1hz) begin
          if (tmr_q == TmrW'(SnoozeTicks - 1)) begin
            state_d    = StRinging;
            ring_cnt_d = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A new alarm time cancels any ring/snooze in progress and suppresses a same-cycle trig.
    if (set_valid && state_q != StIdle) state_d = StArmed;
    if (!bus.alarm_en) state_d = StIdle;
  end

  // Buzzer toggles per tick only while staying in RINGING; starts low on entry.
  always_comb begin
    buzzer_d = 1'b0;
    if (state_q == StRinging && state_d == StRinging) begin
      buzzer_d = bus.tick_1hz ? ~buzzer_q : buzzer_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      ring_cnt_q      <= '0;
      tmr_q           <= '0;
      snooze_cnt_q    <= '0;
      buzzer_q        <= 1'b0;
      match_d_q       <= 1'b0;
      al_min_units_q  <= '0;
      al_min_tens_q   <= '0;
      al_hour_units_q <= '0;
      al_hour_tens_q  <= '0;
    end else begin
      state_q         <= state_d;
      ring_cnt_q      <= ring_cnt_d;
      tmr_q           <= tmr_d;
      snooze_cnt_q    <= snooze_cnt_d;
      buzzer_q        <= buzzer_d;
      match_d_q       <= match_d_d;
      al_min_units_q  <= al_min_units_d;
      al_min_tens_q   <= al_min_tens_d;
      al_hour_units_q <= al_hour_units_d;
      al_hour_tens_q  <= al_hour_tens_d;
    end
  end

  assign bus.al_min_units  = al_min_units_q;
  assign bus.al_min_tens   = al_min_tens_q;
  assign bus.al_hour_units = al_hour_units_q;
  assign bus.al_hour_tens  = al_hour_tens_q;
  assign bus.alarm_ringing = (state_q == StRinging);
  assign bus.snooze_active = (state_q == StSnooze);
  assign bus.buzzer        = buzzer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: table of alarm-capture vectors plus
// hand-written ring, timeout, snooze, priority, disable, reset and wrap sequences.
module tb_alarm_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_controller_if bus_if ();

  alarm_controller dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  mins;
    logic [4:0]  hrs;
    logic [13:0] exp_digits;  // {hour_tens, hour_units, min_tens, min_units}
  } cap_vec_t;

  cap_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] al_digits();
    return {bus_if.al_hour_tens, bus_if.al_hour_units, bus_if.al_min_tens, bus_if.al_min_units};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a time and let one clock edge see it.
  task automatic go_time(input int h, input int m, input int s);
    bus_if.hour_tens  = 3'(h / 10);
    bus_if.hour_units = 4'(h % 10);
    bus_if.min_tens   = 3'(m / 10);
    bus_if.min_units  = 4'(m % 10);
    bus_if.sec_tens   = 3'(s / 10);
    bus_if.sec_units  = 4'(s % 10);
    step();
  endtask

  // Step from one second before HH:MM:00 onto HH:MM:00.
  task automatic hit_time(input int h, input int m);
    go_time(h, m, 1);
    go_time(h, m, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.tick_1hz = 1'b1;
      step();
      bus_if.tick_1hz = 1'b0;
      step();
    end
  endtask

  task automatic press(input logic snz, input logic stp);
    bus_if.snooze_btn = snz;
    bus_if.stop_btn   = stp;
    step();
    bus_if.snooze_btn = 1'b0;
    bus_if.stop_btn   = 1'b0;
  endtask

  task automatic load_alarm(input logic [5:0] m, input logic [4:0] h);
    bus_if.alarm_mins = m;
    bus_if.alarm_hrs  = h;
    bus_if.set_alarm  = 1'b1;
    step();
    bus_if.set_alarm  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mins: 6'd45, hrs: 5'd23, exp_digits: {3'd2, 4'd3, 3'd4, 4'd5}};
    vecs[1] = '{mins: 6'd60, hrs: 5'd5,  exp_digits: {3'd2, 4'd3, 3'd4, 4'd5}};
    vecs[2] = '{mins: 6'd10, hrs: 5'd24, exp_digits: {3'd2, 4'd3, 3'd4, 4'd5}};
    vecs[3] = '{mins: 6'd0,  hrs: 5'd0,  exp_digits: {3'd0, 4'd0, 3'd0, 4'd0}};
    vecs[4] = '{mins: 6'd59, hrs: 5'd9,  exp_digits: {3'd0, 4'd9, 3'd5, 4'd9}};
    vecs[5] = '{mins: 6'd7,  hrs: 5'd12, exp_digits: {3'd1, 4'd2, 3'd0, 4'd7}};
    vecs[6] = '{mins: 6'd63, hrs: 5'd31, exp_digits: {3'd1, 4'd2, 3'd0, 4'd7}};
    vecs[7] = '{mins: 6'd30, hrs: 5'd7,  exp_digits: {3'd0, 4'd7, 3'd3, 4'd0}};

    bus_if.tick_1hz   = 1'b0;
    bus_if.alarm_en   = 1'b0;
    bus_if.set_alarm  = 1'b0;
    bus_if.alarm_mins = '0;
    bus_if.alarm_hrs  = '0;
    bus_if.snooze_btn = 1'b0;
    bus_if.stop_btn   = 1'b0;
    reset = 1'b1;
    go_time(11, 11, 11);
    step();
    step();
    reset = 1'b0;
    step();

    check("reset_al_digits", 32'(al_digits()), 32'h0);
    check("reset_ringing", 32'(bus_if.alarm_ringing), 32'h0);
    check("reset_buzzer", 32'(bus_if.buzzer), 32'h0);
    check("reset_snooze", 32'(bus_if.snooze_active), 32'h0);

    // Capture table, alarm disabled so no state activity.
    for (int i = 0; i < 8; i++) begin
      load_alarm(vecs[i].mins, vecs[i].hrs);
      check($sformatf("capture[%0d]", i), 32'(al_digits()), 32'(vecs[i].exp_digits));
    end

    // Alarm at 07:30 rings on the 07:29:59 -> 07:30:00 transition.
    bus_if.alarm_en = 1'b1;
    go_time(7, 29, 59);
    go_time(7, 30, 0);
    check("ring_start", 32'(bus_if.alarm_ringing), 32'h1);
    check("buzzer_start", 32'(bus_if.buzzer), 32'h0);
    ticks(1);
    check("buzzer_tick1", 32'(bus_if.buzzer), 32'h1);
    ticks(1);
    check("buzzer_tick2", 32'(bus_if.buzzer), 32'h0);
    ticks(57);
    check("ring_59_ticks", 32'(bus_if.alarm_ringing), 32'h1);
    ticks(1);
    check("ring_timeout", 32'(bus_if.alarm_ringing), 32'h0);
    check("buzzer_after_timeout", 32'(bus_if.buzzer), 32'h0);
    repeat (5) step();
    check("no_retrigger_held", 32'(bus_if.alarm_ringing), 32'h0);

    // Snooze three times, fourth snooze acts as stop.
    hit_time(7, 30);
    check("ring_again", 32'(bus_if.alarm_ringing), 32'h1);
    press(1'b1, 1'b0);
    check("snooze1_active", 32'(bus_if.snooze_active), 32'h1);
    check("snooze1_not_ringing", 32'(bus_if.alarm_ringing), 32'h0);
    ticks(299);
    check("snooze_299", 32'(bus_if.snooze_active), 32'h1);
    ticks(1);
    check("snooze_end_ring", 32'(bus_if.alarm_ringing), 32'h1);
    check("snooze_end_inactive", 32'(bus_if.snooze_active), 32'h0);
    for (int k = 2; k <= 3; k++) begin
      press(1'b1, 1'b0);
      check($sformatf("snooze%0d_active", k), 32'(bus_if.snooze_active), 32'h1);
      ticks(300);
      check($sformatf("snooze%0d_ring", k), 32'(bus_if.alarm_ringing), 32'h1);
    end
    press(1'b1, 1'b0);
    check("snooze4_stops_ring", 32'(bus_if.alarm_ringing), 32'h0);
    check("snooze4_no_snooze", 32'(bus_if.snooze_active), 32'h0);

    // Still armed: retrigger, then stop and snooze together -> armed, not snoozing.
    hit_time(7, 30);
    check("armed_after_snooze4", 32'(bus_if.alarm_ringing), 32'h1);
    press(1'b1, 1'b1);
    check("stop_snooze_ringing", 32'(bus_if.alarm_ringing), 32'h0);
    check("stop_snooze_snooze", 32'(bus_if.snooze_active), 32'h0);

    // New event resets the snooze budget; alarm_en drop mid-snooze goes idle.
    hit_time(7, 30);
    check("ring_after_stop", 32'(bus_if.alarm_ringing), 32'h1);
    press(1'b1, 1'b0);
    check("snooze_budget_reset", 32'(bus_if.snooze_active), 32'h1);
    bus_if.alarm_en = 1'b0;
    step();
    check("disable_snooze", 32'(bus_if.snooze_active), 32'h0);
    hit_time(7, 30);
    check("idle_no_ring", 32'(bus_if.alarm_ringing), 32'h0);

    // Valid set_alarm while ringing stores the time and silences the ring.
    bus_if.alarm_en = 1'b1;
    step();
    hit_time(7, 30);
    check("ring_before_set", 32'(bus_if.alarm_ringing), 32'h1);
    load_alarm(6'd15, 5'd8);
    check("set_in_ring_silences", 32'(bus_if.alarm_ringing), 32'h0);
    check("set_in_ring_digits", 32'(al_digits()), 32'({3'd0, 4'd8, 3'd1, 4'd5}));

    // Reset mid-ring with buzzer high.
    hit_time(8, 15);
    ticks(1);
    check("buzzer_before_reset", 32'(bus_if.buzzer), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_ring_ringing", 32'(bus_if.alarm_ringing), 32'h0);
    check("reset_ring_buzzer", 32'(bus_if.buzzer), 32'h0);
    check("reset_ring_snooze", 32'(bus_if.snooze_active), 32'h0);
    check("reset_ring_digits", 32'(al_digits()), 32'h0);

    // Midnight wrap triggers an alarm set to 00:00.
    step();
    go_time(23, 59, 59);
    go_time(0, 0, 0);
    check("wrap_ring", 32'(bus_if.alarm_ringing), 32'h1);
    press(1'b0, 1'b1);
    check("wrap_stop", 32'(bus_if.alarm_ringing), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
